// File: rtl/i2c_ctrl_driver.sv
// i2c_ctrl_driver: I2C bus-master byte engine (START / STOP / WRITE / READ).
// Drives open-drain SCL/SDA enables and samples the synchronized wired-AND bus.
// Optional build macro I2C_CTRL_CLK_STRETCH_EN enables target clock stretching.
module i2c_ctrl_driver #(
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_ack,
    output logic       rsp_arb,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_BIT, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] qcnt, qcnt_nxt;
    logic [1:0]       phase, phase_nxt;
    logic [3:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [1:0]       op_q, op_nxt;
    logic             nack_q, nack_nxt;
    logic             ack_q, ack_nxt;
    logic             cmd_ready_nxt, rsp_valid_nxt, rsp_ack_nxt, rsp_arb_nxt;
    logic [7:0]       rsp_data_nxt;
    logic             scl_oe_nxt, sda_oe_nxt;
    logic             scl_ff, scl_s, sda_ff, sda_s;
    logic             stretch_hold;
    logic             term, step, accept, lost;
    logic [3:0]       nbit;

    // Two-flop synchronizers for the asynchronous bus lines (idle bus reads high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_ff <= 1'b1;
            scl_s  <= 1'b1;
            sda_ff <= 1'b1;
            sda_s  <= 1'b1;
        end else begin
            scl_ff <= scl_in;
            scl_s  <= scl_ff;
            sda_ff <= sda_in;
            sda_s  <= sda_ff;
        end
    end

`ifdef I2C_CTRL_CLK_STRETCH_EN
    logic scl_oe_d1, scl_oe_d2;

    // Own SCL drive delayed to line up with the synchronizer latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_oe_d1 <= 1'b0;
            scl_oe_d2 <= 1'b0;
        end else begin
            scl_oe_d1 <= scl_oe;
            scl_oe_d2 <= scl_oe_d1;
        end
    end

    // Stall only when SCL is still low after our release has reached the synchronizer
    assign stretch_hold = (phase == 2'd1) && ((state == S_START) || (state == S_BIT)) &&
                          !scl_s && !scl_oe_d2;
`else
    logic unused_scl_s;
    assign unused_scl_s = scl_s;
    assign stretch_hold = 1'b0;
`endif

    assign term   = (qcnt == CNT_W'(CLKDIV - 1));
    assign accept = cmd_valid && cmd_ready && !rsp_valid;

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        qcnt_nxt      = qcnt;
        phase_nxt     = phase;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        op_nxt        = op_q;
        nack_nxt      = nack_q;
        ack_nxt       = ack_q;
        cmd_ready_nxt = cmd_ready;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        rsp_ack_nxt   = rsp_ack;
        rsp_arb_nxt   = rsp_arb;
        scl_oe_nxt    = scl_oe;
        sda_oe_nxt    = sda_oe;
        step          = 1'b0;
        lost          = 1'b0;
        nbit          = bit_idx + 4'd1;

        // Quarter-phase timing shared by START, STOP and BIT
        if (((state == S_START) || (state == S_STOP) || (state == S_BIT)) && !stretch_hold) begin
            if (term) begin
                qcnt_nxt  = '0;
                phase_nxt = phase + 2'd1;
                step      = 1'b1;
            end else begin
                qcnt_nxt = qcnt + CNT_W'(1);
            end
        end

        case (state)
            S_IDLE: begin
                if (accept) begin
                    cmd_ready_nxt = 1'b0;
                    rsp_arb_nxt   = 1'b0;
                    qcnt_nxt      = '0;
                    phase_nxt     = 2'd0;
                    bit_idx_nxt   = 4'd0;
                    shreg_nxt     = cmd_data;
                    op_nxt        = cmd_op;
                    nack_nxt      = cmd_nack;
                    ack_nxt       = 1'b0;
                    case (cmd_op)
                        OP_START: begin
                            state_nxt  = S_START;
                            sda_oe_nxt = 1'b0;
                        end
                        OP_STOP: begin
                            state_nxt  = S_STOP;
                            sda_oe_nxt = 1'b1;
                        end
                        default: begin
                            state_nxt  = S_BIT;
                            scl_oe_nxt = 1'b1;
                            sda_oe_nxt = (cmd_op == OP_WRITE) ? ~cmd_data[7] : 1'b0;
                        end
                    endcase
                end
            end
            S_START: begin
                if (step) begin
                    case (phase)
                        2'd0:    scl_oe_nxt = 1'b0;
                        2'd1:    sda_oe_nxt = 1'b1;
                        2'd2:    scl_oe_nxt = 1'b1;
                        default: state_nxt  = S_DONE;
                    endcase
                end
            end
            S_STOP: begin
                if (step) begin
                    case (phase)
                        2'd0:    scl_oe_nxt = 1'b0;
                        2'd1:    sda_oe_nxt = 1'b0;
                        2'd2:    ;
                        default: state_nxt  = S_DONE;
                    endcase
                end
            end
            S_BIT: begin
                if (step) begin
                    case (phase)
                        2'd0: scl_oe_nxt = 1'b0;
                        2'd1: ;
                        2'd2: begin
                            // Sample point: data shift, arbitration check or ACK capture
                            if (bit_idx < 4'd8) begin
                                if (op_q == OP_READ) begin
                                    shreg_nxt = {shreg[6:0], sda_s};
                                end else if (!sda_oe && !sda_s) begin
                                    lost = 1'b1;
                                end
                            end else begin
                                ack_nxt = ~sda_s;
                            end
                            if (lost) begin
                                scl_oe_nxt  = 1'b0;
                                sda_oe_nxt  = 1'b0;
                                rsp_arb_nxt = 1'b1;
                                state_nxt   = S_DONE;
                            end else begin
                                scl_oe_nxt = 1'b1;
                            end
                        end
                        default: begin
                            if (bit_idx == 4'd8) begin
                                state_nxt = S_DONE;
                            end else begin
                                bit_idx_nxt = nbit;
                                if (nbit == 4'd8) begin
                                    sda_oe_nxt = (op_q == OP_READ) ? ~nack_q : 1'b0;
                                end else begin
                                    sda_oe_nxt = (op_q == OP_READ) ? 1'b0 : ~shreg[3'(4'd7 - nbit)];
                                end
                            end
                        end
                    endcase
                end
            end
            S_DONE: begin
                state_nxt     = S_IDLE;
                rsp_valid_nxt = 1'b1;
                cmd_ready_nxt = 1'b1;
                if (rsp_arb) begin
                    rsp_ack_nxt = 1'b0;
                end else if (op_q == OP_WRITE) begin
                    rsp_ack_nxt = ack_q;
                end else if (op_q == OP_READ) begin
                    rsp_data_nxt = shreg;
                    rsp_ack_nxt  = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            qcnt      <= '0;
            phase     <= 2'd0;
            bit_idx   <= 4'd0;
            shreg     <= 8'd0;
            op_q      <= OP_START;
            nack_q    <= 1'b0;
            ack_q     <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'd0;
            rsp_ack   <= 1'b0;
            rsp_arb   <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            state     <= state_nxt;
            qcnt      <= qcnt_nxt;
            phase     <= phase_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            op_q      <= op_nxt;
            nack_q    <= nack_nxt;
            ack_q     <= ack_nxt;
            cmd_ready <= cmd_ready_nxt;
            busy      <= ~cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_ack   <= rsp_ack_nxt;
            rsp_arb   <= rsp_arb_nxt;
            scl_oe    <= scl_oe_nxt;
            sda_oe    <= sda_oe_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_ctrl_driver.sv
// Directed bench for i2c_ctrl_driver with a simple open-drain target model.
module tb_i2c_ctrl_driver;

    localparam int unsigned CLKDIV = 4;
    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;

    logic       clk, rst_n;
    logic       cmd_valid, cmd_ready, cmd_nack;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data, rsp_data;
    logic       rsp_valid, rsp_ack, rsp_arb, busy;
    logic       scl_oe, sda_oe, scl_in, sda_in;
    logic       tgt_sda_pull, tgt_scl_pull;

    int         n_checks, n_fail;
    int         r_cyc, sda_rise, scl_rise;
    logic [7:0] r_data, pat;
    logic       r_ack, r_arb, r_after, b9_or, b9_and, scl44, sda44;

    // Wired-AND bus: either side may pull low
    assign scl_in = ~scl_oe & ~tgt_scl_pull;
    assign sda_in = ~sda_oe & ~tgt_sda_pull;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    i2c_ctrl_driver #(.CLKDIV(CLKDIV), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_nack  (cmd_nack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ack   (rsp_ack),
        .rsp_arb   (rsp_arb),
        .busy      (busy),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command, play the target, record timing and response fields.
    // Cycle k = k-th rising edge after the accept edge, sampled 1ns later.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic nack,
                           input logic [7:0] rd_byte, input logic ack_pull,
                           input int arb_bit, input int stretch);
        int guard;
        int b;
        guard = 0;
        @(negedge clk);
        while (!(cmd_ready && !rsp_valid) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check("ready_timeout", 32'd0, 32'd1);
        cmd_op    = op;
        cmd_data  = data;
        cmd_nack  = nack;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        r_cyc = -1; sda_rise = -1; scl_rise = -1;
        pat = 8'd0; b9_or = 1'b0; b9_and = 1'b1; r_after = 1'b1;
        scl44 = 1'b1; sda44 = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (sda_oe && sda_rise < 0) sda_rise = k;
            if (scl_oe && scl_rise < 0) scl_rise = k;
            if (k == 44) begin
                scl44 = scl_oe;
                sda44 = sda_oe;
            end
            if ((k % 16) == 8 && k < 136) pat = {pat[6:0], sda_oe};
            if (k > 128 && k <= 144) begin
                b9_or  = b9_or | sda_oe;
                b9_and = b9_and & sda_oe;
            end
            if (r_cyc >= 0) begin
                r_after = rsp_valid;
                break;
            end
            if (rsp_valid) begin
                r_cyc  = k;
                r_data = rsp_data;
                r_ack  = rsp_ack;
                r_arb  = rsp_arb;
            end
            // Target: per-bit SDA pulls, optional SCL stretch in bit 1
            b = k / 16;
            tgt_sda_pull = 1'b0;
            if (r_cyc < 0) begin
                if (op == OP_READ && b < 8) tgt_sda_pull = ~rd_byte[7 - b];
                if (op == OP_WRITE && b == 8 && ack_pull) tgt_sda_pull = 1'b1;
                if (b == arb_bit) tgt_sda_pull = 1'b1;
            end
            tgt_scl_pull = (stretch > 0) && (k < 4 + stretch);
        end
        if (r_cyc < 0) check("rsp_timeout", 32'd0, 32'd1);
        tgt_sda_pull = 1'b0;
        tgt_scl_pull = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'd0; cmd_nack = 1'b0;
        tgt_sda_pull = 1'b0; tgt_scl_pull = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_scl_oe", 32'(scl_oe), 32'd0);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_ack_arb", 32'({rsp_ack, rsp_arb}), 32'd0);

        // START from idle bus
        run_cmd(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0);
        check("start_sda_rise", 32'(sda_rise), 32'd8);
        check("start_scl_rise", 32'(scl_rise), 32'd12);
        check("start_rsp_cyc", 32'(r_cyc), 32'd17);
        check("start_rsp_pulse", 32'(r_after), 32'd0);

        // WRITE 0xA5, target ACKs
        run_cmd(OP_WRITE, 8'hA5, 1'b0, 8'h00, 1'b1, -1, 0);
        check("wr_ack_cyc", 32'(r_cyc), 32'd145);
        check("wr_ack_pattern", 32'(pat), 32'h5A);
        check("wr_ack_ack", 32'(r_ack), 32'd1);
        check("wr_ack_arb", 32'(r_arb), 32'd0);
        check("wr_ack_data", 32'(r_data), 32'd0);

        // WRITE 0xA5, no ACK
        run_cmd(OP_WRITE, 8'hA5, 1'b0, 8'h00, 1'b0, -1, 0);
        check("wr_nack_cyc", 32'(r_cyc), 32'd145);
        check("wr_nack_ack", 32'(r_ack), 32'd0);

        // READ 0x3C, controller NACKs
        run_cmd(OP_READ, 8'h00, 1'b1, 8'h3C, 1'b0, -1, 0);
        check("rd_nack_cyc", 32'(r_cyc), 32'd145);
        check("rd_nack_data", 32'(r_data), 32'h3C);
        check("rd_nack_ack", 32'(r_ack), 32'd0);
        check("rd_nack_released", 32'(pat), 32'd0);
        check("rd_nack_bit9", 32'(b9_or), 32'd0);

        // READ 0xC3, controller ACKs
        run_cmd(OP_READ, 8'h00, 1'b0, 8'hC3, 1'b0, -1, 0);
        check("rd_ack_data", 32'(r_data), 32'hC3);
        check("rd_ack_bit9", 32'(b9_and), 32'd1);

        // WRITE 0xFF, another master pulls SDA on bit 3
        run_cmd(OP_WRITE, 8'hFF, 1'b0, 8'h00, 1'b0, 2, 0);
        check("arb_cyc", 32'(r_cyc), 32'd45);
        check("arb_flag", 32'(r_arb), 32'd1);
        check("arb_scl_rel", 32'(scl44), 32'd0);
        check("arb_sda_rel", 32'(sda44), 32'd0);
        check("arb_data_held", 32'(r_data), 32'hC3);

        // STOP clears the arbitration flag and leaves the bus released
        run_cmd(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b0, -1, 0);
        check("stop_cyc", 32'(r_cyc), 32'd17);
        check("stop_arb_clr", 32'(r_arb), 32'd0);
        check("stop_lines", 32'({scl_oe, sda_oe}), 32'd0);

        // Held cmd_valid: ignored while busy and in the response cycle
        @(negedge clk);
        cmd_op = OP_START; cmd_data = 8'h00; cmd_nack = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_op = OP_STOP;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 10) check("hold_busy", 32'({busy, cmd_ready}), 32'd2);
            if (k == 17) check("hold_rsp1", 32'(rsp_valid), 32'd1);
            if (k == 18) check("hold_no_accept", 32'({cmd_ready, rsp_valid}), 32'd2);
            if (k == 19) begin
                check("hold_accept", 32'(cmd_ready), 32'd0);
                cmd_valid = 1'b0;
            end
            if (k == 36) check("hold_rsp2", 32'(rsp_valid), 32'd1);
        end

        // Target holds SCL 20 extra cycles in bit 1
        run_cmd(OP_WRITE, 8'h5A, 1'b0, 8'h00, 1'b0, -1, 20);
`ifdef I2C_CTRL_CLK_STRETCH_EN
        check("stretch_cyc", 32'(r_cyc), 32'd165);
`else
        check("stretch_cyc", 32'(r_cyc), 32'd145);
`endif
        check("stretch_ack", 32'(r_ack), 32'd0);

        // Async reset mid-WRITE releases both lines at once
        @(negedge clk);
        cmd_op = OP_WRITE; cmd_data = 8'h00; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 check("mid_lines_driven", 32'({scl_oe, sda_oe}), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("arst_lines", 32'({scl_oe, sda_oe}), 32'd0);
        check("arst_ready", 32'({cmd_ready, busy}), 32'd2);
        #10 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
